// File: rtl/ext_mem_pkg.sv
// Shared types and sizing helpers for the external RAM bus arbiter.
package ext_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  // Wide enough to count down from the longer of the two wait phases.
  function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                            input int unsigned wr_pulse);
    int unsigned m;
    m = (rd_wait > wr_pulse) ? rd_wait : wr_pulse;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: masked requests, priority flips toward the loser on update.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       update,
  output logic [1:0] gnt
);

  logic       prio_q;  // 0: port 0 favoured, 1: port 1 favoured
  logic [1:0] eff_req;

  assign eff_req = req & ~mask;

  always_comb begin
    gnt = 2'b00;
    case (eff_req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (update && (gnt != 2'b00)) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Owns the off-chip RAM pins: arbitrates CPU (port 0) and loader (port 1) and sequences
// each access so the address is stable around the write strobe.
module ext_mem_arbiter
  import ext_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = cnt_width(RD_WAIT, WR_PULSE);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              oe_q, oe_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [1:0]        gnt;

  // A port whose ack is showing is masked so a not-yet-dropped request is not re-served.
  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1 & en, req0 & en}),
    .mask   ({ack1_q, ack0_q}),
    .update (state_q == StIdle),
    .gnt    (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d    = 1'b0;
    oe_d    = oe_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        oe_d    = 1'b0;
        wdata_d = '0;
        if (gnt != 2'b00) begin
          port_d = gnt[1];
          addr_d = gnt[1] ? addr1 : addr0;
          if (gnt[1] ? we1 : we0) begin
            wdata_d = gnt[1] ? wdata1 : wdata0;
            oe_d    = 1'b1;
            state_d = StWrSetup;
          end else begin
            cnt_d   = CntW'(RD_WAIT - 1);
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrSetup: begin
        rw_d    = 1'b1;
        cnt_d   = CntW'(WR_PULSE - 1);
        state_d = StWrPulse;
      end
      StWrPulse: begin
        if (cnt_q == '0) begin
          state_d = StWrHold;
        end else begin
          rw_d  = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrHold: begin
        oe_d    = 1'b0;
        wdata_d = '0;
        ack0_d  = ~port_q;
        ack1_d  = port_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_rw      = rw_q;
  assign mem_wdata   = wdata_q;
  assign mem_data_oe = oe_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench: default build (instance 0) and RD_WAIT=3/WR_PULSE=2 build (instance 1).
module tb_ext_mem_arbiter;

  logic clk;
  logic rst_n;
  logic en;

  logic [1:0]       req0, req1, we0, we1, ack0, ack1, mem_rw, oe;
  logic [1:0][10:0] addr0, addr1, mem_addr;
  logic [1:0][3:0]  wdata0, wdata1, rdata, mem_wdata, mem_rdata;

  logic [3:0] ram0 [2048];
  logic [3:0] ram1 [2048];

  logic        pl_we;
  int          pl_d;
  logic [10:0] pl_addr;
  logic [3:0]  pl_val;

  int checks;
  int failures;
  int inv_err;

  logic [1:0]       prev_rw;
  logic [1:0][10:0] prev_addr;

  ext_mem_arbiter u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rdata[0]),
    .mem_addr(mem_addr[0]), .mem_rw(mem_rw[0]), .mem_wdata(mem_wdata[0]),
    .mem_data_oe(oe[0]), .mem_rdata(mem_rdata[0])
  );

  ext_mem_arbiter #(.RD_WAIT(3), .WR_PULSE(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rdata[1]),
    .mem_addr(mem_addr[1]), .mem_rw(mem_rw[1]), .mem_wdata(mem_wdata[1]),
    .mem_data_oe(oe[1]), .mem_rdata(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata[0] = ram0[mem_addr[0]];
  assign mem_rdata[1] = ram1[mem_addr[1]];

  // RAM model: writes land on the clock edge while the strobe is high.
  always @(posedge clk) begin
    if (mem_rw[0]) ram0[mem_addr[0]] <= mem_wdata[0];
    if (mem_rw[1]) ram1[mem_addr[1]] <= mem_wdata[1];
    if (pl_we && pl_d == 0) ram0[pl_addr] <= pl_val;
    if (pl_we && pl_d == 1) ram1[pl_addr] <= pl_val;
  end

  // Pin invariants, sampled mid-cycle.
  always @(negedge clk) begin
    int e;
    e = 0;
    for (int i = 0; i < 2; i++) begin
      if (rst_n && (mem_rw[i] || prev_rw[i]) && mem_addr[i] != prev_addr[i]) e++;
      if (ack0[i] && ack1[i]) e++;
      if (mem_rw[i] && !oe[i]) e++;
    end
    inv_err   <= inv_err + e;
    prev_rw   <= rst_n ? mem_rw : 2'b00;
    prev_addr <= mem_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ram_rd(input int d, input logic [10:0] a);
    return (d == 0) ? ram0[a] : ram1[a];
  endfunction

  task automatic preload(input int d, input logic [10:0] a, input logic [3:0] v);
    pl_d = d; pl_addr = a; pl_val = v; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic set_req(input int d, input bit p, input bit w, input logic [10:0] a,
                         input logic [3:0] wd, input bit r);
    if (p) begin
      we1[d] = w; addr1[d] = a; wdata1[d] = wd; req1[d] = r;
    end else begin
      we0[d] = w; addr0[d] = a; wdata0[d] = wd; req0[d] = r;
    end
  endtask

  // Issue one request; the first edge after the call is the grant edge (k=0).
  task automatic run_txn(input int d, input bit p, input bit w, input logic [10:0] a,
                         input logic [3:0] wd, output int lat, output int rwc, output int oec,
                         output logic [10:0] a_seen, output bit stable);
    lat = -1; rwc = 0; oec = 0; stable = 1'b1; a_seen = '0;
    set_req(d, p, w, a, wd, 1'b1);
    for (int k = 0; k < 32 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 0) a_seen = mem_addr[d];
      else if (mem_addr[d] != a_seen) stable = 1'b0;
      if (mem_rw[d]) rwc++;
      if (oe[d]) oec++;
      if (p ? ack1[d] : ack0[d]) lat = k;
    end
    set_req(d, p, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          d;
    bit          p;
    bit          w;
    logic [10:0] a;
    logic [3:0]  wd;
    bit          pre;
    logic [3:0]  pv;
    logic [3:0]  exp;
    int          lat;
    int          rwc;
    int          oec;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          lat, rwc, oec, nack;
    bit          stable;
    logic [10:0] a_seen, a_before;
    int          order [4];
    logic [3:0]  rd_at [4];

    checks = 0; failures = 0; inv_err = 0;
    prev_rw = '0; prev_addr = '0;
    pl_we = 1'b0; pl_d = 0; pl_addr = '0; pl_val = '0;
    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    en = 1'b1;
    rst_n = 1'b1;

    vecs[0] = '{0, 1'b0, 1'b0, 11'h123, 4'h0, 1'b1, 4'hA, 4'hA, 1, 0, 0};
    vecs[1] = '{0, 1'b1, 1'b1, 11'h7FE, 4'h5, 1'b0, 4'h0, 4'h5, 3, 1, 3};
    vecs[2] = '{0, 1'b1, 1'b0, 11'h7FE, 4'h0, 1'b0, 4'h0, 4'h5, 1, 0, 0};
    vecs[3] = '{0, 1'b0, 1'b1, 11'h000, 4'hF, 1'b1, 4'h2, 4'hF, 3, 1, 3};
    vecs[4] = '{0, 1'b0, 1'b0, 11'h456, 4'h0, 1'b1, 4'h0, 4'h0, 1, 0, 0};
    vecs[5] = '{1, 1'b0, 1'b0, 11'h3C3, 4'h0, 1'b1, 4'h6, 4'h6, 3, 0, 0};
    vecs[6] = '{1, 1'b1, 1'b1, 11'h001, 4'h9, 1'b0, 4'h0, 4'h9, 4, 2, 4};
    vecs[7] = '{1, 1'b0, 1'b0, 11'h001, 4'h0, 1'b0, 4'h0, 4'h9, 3, 0, 0};

    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_addr%0d", i), 32'(mem_addr[i]), 32'h0);
      chk($sformatf("rst_pins%0d", i), {29'b0, mem_rw[i], oe[i], ack0[i] | ack1[i]}, 32'h0);
      chk($sformatf("rst_data%0d", i), {24'b0, mem_wdata[i], rdata[i]}, 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].pre) preload(vecs[v].d, vecs[v].a, vecs[v].pv);
      run_txn(vecs[v].d, vecs[v].p, vecs[v].w, vecs[v].a, vecs[v].wd, lat, rwc, oec, a_seen,
              stable);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("v%0d_rw_cycles", v), 32'(rwc), 32'(vecs[v].rwc));
      chk($sformatf("v%0d_oe_cycles", v), 32'(oec), 32'(vecs[v].oec));
      chk($sformatf("v%0d_addr", v), 32'(a_seen), 32'(vecs[v].a));
      chk($sformatf("v%0d_addr_stable", v), 32'(stable), 32'd1);
      if (vecs[v].w) chk($sformatf("v%0d_ram", v), 32'(ram_rd(vecs[v].d, vecs[v].a)),
                         32'(vecs[v].exp));
      else chk($sformatf("v%0d_rdata", v), 32'(rdata[vecs[v].d]), 32'(vecs[v].exp));
    end

    // Both ports held: expect alternation starting at port 0, no duplicates.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    preload(0, 11'h010, 4'h1);
    preload(0, 11'h020, 4'h2);
    set_req(0, 1'b0, 1'b0, 11'h010, 4'h0, 1'b1);
    set_req(0, 1'b1, 1'b0, 11'h020, 4'h0, 1'b1);
    nack = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if ((ack0[0] || ack1[0]) && nack < 4) begin
        order[nack] = ack1[0] ? 1 : 0;
        rd_at[nack] = rdata[0];
        nack++;
      end
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    chk("rr_ack_count", 32'(nack), 32'd4);
    for (int i = 0; i < 4 && i < nack; i++) begin
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
      chk($sformatf("rr_rdata%0d", i), 32'(rd_at[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    nack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack0[0] || ack1[0] || oe[0]) nack++;
    end
    chk("rr_no_extra", 32'(nack), 32'd0);

    // Reset asserted while the write strobe is high.
    preload(0, 11'h155, 4'h3);
    preload(0, 11'h000, 4'h9);
    set_req(0, 1'b1, 1'b1, 11'h155, 4'hC, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstw_rw_before", 32'(mem_rw[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_rw_drop", 32'(mem_rw[0]), 32'd0);
    chk("rstw_oe_drop", 32'(oe[0]), 32'd0);
    chk("rstw_addr", 32'(mem_addr[0]), 32'd0);
    set_req(0, 1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack1[0] || ack0[0]) nack++;
    end
    chk("rstw_no_ack", 32'(nack), 32'd0);
    chk("rstw_ram_target", 32'(ram0[11'h155]), 32'h3);
    chk("rstw_ram_zero", 32'(ram0[11'h000]), 32'h9);
    run_txn(0, 1'b1, 1'b0, 11'h155, 4'h0, lat, rwc, oec, a_seen, stable);
    chk("rstw_idle_latency", 32'(lat), 32'd1);
    chk("rstw_idle_rdata", 32'(rdata[0]), 32'h3);

    // en low holds off grants; raising it grants on the next edge.
    preload(0, 11'h0AB, 4'h7);
    a_before = mem_addr[0];
    en = 1'b0;
    set_req(0, 1'b0, 1'b0, 11'h0AB, 4'h0, 1'b1);
    nack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack0[0] || mem_rw[0] || oe[0] || mem_addr[0] != a_before) nack++;
    end
    chk("en0_idle", 32'(nack), 32'd0);
    en = 1'b1;
    @(posedge clk); #1;
    chk("en1_grant_addr", 32'(mem_addr[0]), 32'h0AB);
    @(posedge clk); #1;
    chk("en1_ack", 32'(ack0[0]), 32'd1);
    chk("en1_rdata", 32'(rdata[0]), 32'h7);
    req0[0] = 1'b0;
    @(posedge clk); #1;

    // en dropped mid-read on the slow build: read still completes.
    set_req(1, 1'b0, 1'b0, 11'h3C3, 4'h0, 1'b1);
    @(posedge clk); #1;
    en = 1'b0;
    lat = -1;
    for (int k = 1; k < 12 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ack0[1]) lat = k;
    end
    chk("en_drop_latency", 32'(lat), 32'd3);
    chk("en_drop_rdata", 32'(rdata[1]), 32'h6);
    req0[1] = 1'b0;
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 11'h001, 4'h0, 1'b1);
    nack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack1[1] || mem_addr[1] != 11'h3C3) nack++;
    end
    chk("en_drop_stays_idle", 32'(nack), 32'd0);
    req1[1] = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;

    chk("pin_invariants", 32'(inv_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
